// File: rtl/counter_wrap.sv
// Enable-gated WIDTH-bit up-counter wrapping modulo 2**WIDTH, with a
// selectable incrementer micro-architecture (behavioural, ripple, prefix).
module counter_wrap #(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] sum;

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("counter_wrap: WIDTH must be in 1..64");
        end

        if (IMPLEMENTATION == 0) begin : g_behav
            assign sum = cnt + WIDTH'(1);
        end else if (IMPLEMENTATION == 1) begin : g_ripple
            logic [WIDTH-1:0] carry;
            always_comb begin
                carry    = '0;
                carry[0] = 1'b1;
                for (int unsigned i = 1; i < WIDTH; i++) begin
                    carry[i] = cnt[i-1] & carry[i-1];
                end
            end
            assign sum = cnt ^ carry;
        end else if (IMPLEMENTATION == 2) begin : g_prefix
            localparam int unsigned LEVELS = $clog2(WIDTH);
            logic [WIDTH-1:0] pre [0:LEVELS];
            // Level 0 holds {cnt, 1} shifted up one bit, so the inclusive
            // prefix-AND at bit i is directly the carry into bit i.
            always_comb begin
                for (int unsigned k = 0; k <= LEVELS; k++) begin
                    pre[k] = '0;
                end
                pre[0][0] = 1'b1;
                for (int unsigned i = 1; i < WIDTH; i++) begin
                    pre[0][i] = cnt[i-1];
                end
                for (int unsigned k = 0; k < LEVELS; k++) begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (i >= (32'd1 << k)) begin
                            pre[k+1][i] = pre[k][i] & pre[k][i - (32'd1 << k)];
                        end else begin
                            pre[k+1][i] = pre[k][i];
                        end
                    end
                end
            end
            assign sum = cnt ^ pre[LEVELS];
        end else begin : g_bad_impl
            $error("counter_wrap: IMPLEMENTATION must be 0, 1 or 2");
            assign sum = cnt;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= sum;
        end
    end

endmodule

// File: tb/tb_counter_wrap.sv
// Bench for counter_wrap: nine instances (WIDTH 1/4/13 x IMPLEMENTATION 0/1/2)
// on shared stimulus, each checked against an integer reference count.
module tb_counter_wrap;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b0;

    logic [63:0] outs [9];

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference: plain integer count of enabled edges since the last reset.
    longint unsigned model = 0;

    always #5 clk = ~clk;

    function automatic int unsigned width_of(input int unsigned j);
        return (j < 3) ? 1 : (j < 6) ? 4 : 13;
    endfunction

    function automatic longint unsigned expect_of(input int unsigned j);
        return model % (64'd1 << width_of(j));
    endfunction

    for (genvar w = 0; w < 3; w++) begin : g_w
        for (genvar m = 0; m < 3; m++) begin : g_m
            localparam int unsigned W = (w == 0) ? 1 : (w == 1) ? 4 : 13;
            logic [W-1:0] c;
            counter_wrap #(.WIDTH(W), .IMPLEMENTATION(m)) dut (
                .clk(clk),
                .rst(rst),
                .ena(ena),
                .cnt(c)
            );
            assign outs[w*3+m] = 64'(c);
        end
    end

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic tick(input logic r, input logic e);
        rst = r;
        ena = e;
        @(posedge clk);
        #1;
        if (r) model = 0;
        else if (e) model = model + 1;
    endtask

    task automatic test_reset;
        for (int unsigned c = 0; c < 5; c++) begin
            // four reset cycles, then one released edge with ena low
            tick(c < 4, 1'($urandom_range(0, 1)) & (c < 4));
            for (int unsigned j = 0; j < 9; j++) begin
                tests++;
                if (outs[j] !== 64'd0) begin
                    fails++;
                    $display("FAIL reset c=%0d dut%0d (W=%0d impl=%0d): got %0d, expected 0",
                             c, j, width_of(j), j % 3, outs[j]);
                end
            end
        end
    endtask

    task automatic test_enable_gating;
        for (int unsigned c = 0; c < 8; c++) begin
            tick(1'b0, c >= 5);
            for (int unsigned j = 0; j < 9; j++) begin
                tests++;
                if (outs[j] !== 64'(expect_of(j))) begin
                    fails++;
                    $display("FAIL enable_gating c=%0d dut%0d (W=%0d impl=%0d): got %0d, expected %0d",
                             c, j, width_of(j), j % 3, outs[j], expect_of(j));
                end
            end
        end
        // after 5 idle and 3 enabled edges the count must be exactly 3
        tests++;
        if (outs[3] !== 64'd3) begin
            fails++;
            $display("FAIL enable_gating_final: got %0d, expected 3", outs[3]);
        end
    endtask

    task automatic test_wrap;
        tick(1'b1, 1'b0);
        for (int unsigned c = 1; c <= 18; c++) begin
            tick(1'b0, 1'b1);
            for (int unsigned j = 3; j < 6; j++) begin
                tests++;
                if (outs[j] !== 64'(c % 16)) begin
                    fails++;
                    $display("FAIL wrap c=%0d dut%0d (W=4 impl=%0d): got %0d, expected %0d",
                             c, j, j % 3, outs[j], c % 16);
                end
            end
            for (int unsigned j = 0; j < 9; j++) begin
                tests++;
                if (outs[j] !== 64'(expect_of(j))) begin
                    fails++;
                    $display("FAIL wrap_all c=%0d dut%0d (W=%0d impl=%0d): got %0d, expected %0d",
                             c, j, width_of(j), j % 3, outs[j], expect_of(j));
                end
            end
        end
    endtask

    task automatic test_random_enable;
        int unsigned enabled = 0;
        int unsigned cycles  = 0;
        tick(1'b1, 1'b1);
        // enough enabled edges to wrap the 13-bit counter at least once
        while (enabled < 8200 && cycles < 20000) begin
            logic e;
            e = ($urandom_range(0, 3) != 0);
            tick(1'b0, e);
            if (e) enabled++;
            cycles++;
            for (int unsigned j = 0; j < 9; j++) begin
                tests++;
                if (outs[j] !== 64'(expect_of(j))) begin
                    fails++;
                    $display("FAIL random_enable cyc=%0d dut%0d (W=%0d impl=%0d): got %0d, expected %0d",
                             cycles, j, width_of(j), j % 3, outs[j], expect_of(j));
                end
            end
        end
        tests++;
        if (enabled < 8200) begin
            fails++;
            $display("FAIL random_enable_budget: got %0d enabled counts, expected >= 8200", enabled);
        end
    endtask

    task automatic test_reset_midcount;
        tick(1'b1, 1'b0);
        for (int unsigned c = 0; c < 9; c++) tick(1'b0, 1'b1);
        tests++;
        if (outs[6] !== 64'd9) begin
            fails++;
            $display("FAIL midcount_pre: got %0d, expected 9", outs[6]);
        end
        tick(1'b1, 1'b1);
        for (int unsigned j = 0; j < 9; j++) begin
            tests++;
            if (outs[j] !== 64'd0) begin
                fails++;
                $display("FAIL midcount_reset dut%0d (W=%0d impl=%0d): got %0d, expected 0",
                         j, width_of(j), j % 3, outs[j]);
            end
        end
        for (int unsigned c = 1; c <= 3; c++) begin
            tick(1'b0, 1'b1);
            for (int unsigned j = 3; j < 9; j++) begin
                tests++;
                if (outs[j] !== 64'(c)) begin
                    fails++;
                    $display("FAIL midcount_resume c=%0d dut%0d (W=%0d impl=%0d): got %0d, expected %0d",
                             c, j, width_of(j), j % 3, outs[j], c);
                end
            end
        end
    endtask

    task automatic test_equivalence;
        // random rst and ena together; every instance must track the model
        for (int unsigned c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)));
            for (int unsigned j = 0; j < 9; j++) begin
                tests++;
                if (outs[j] !== 64'(expect_of(j))) begin
                    fails++;
                    $display("FAIL equivalence c=%0d dut%0d (W=%0d impl=%0d): got %0d, expected %0d",
                             c, j, width_of(j), j % 3, outs[j], expect_of(j));
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_enable_gating();
        test_wrap();
        test_random_enable();
        test_reset_midcount();
        test_equivalence();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
